// File: rtl/display_scanner_pkg.sv
// Shared types and constants for the
// multiplexed seven-segment scanner.
package display_scanner_pkg;

  typedef enum logic {
    BLANK,
    DRIVE
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

endpackage

// File: rtl/display_scanner_if.sv
// Load/display bundle between a host
// and the display scanner.
interface display_scanner_if;

  logic [15:0] data;
  logic [3:0]  dp_mask;
  logic        load;
  logic        lzb;
  logic        pending;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        dp;

  modport master (
    output data, dp_mask, load, lzb,
    input  pending, nibble, an, dp
  );

  modport slave (
    input  data, dp_mask, load, lzb,
    output pending, nibble, an, dp
  );

endinterface

// File: rtl/display_scanner_timer.sv
// Slot timer: cycle count, digit index
// and BLANK/DRIVE state per slot.
module scan_timer
  import display_scanner_pkg::*;
#(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000,
  localparam int CW = $clog2(PRESCALE)
) (
  input  logic       clk,
  input  logic       rst_n,
  output state_t     state,
  output logic [1:0] idx,
  output logic       frame_end
);

  logic [CW-1:0] cnt;
  state_t        state_nx;
  logic          blank_end;
  logic          slot_end;

  assign blank_end = (state == BLANK) &&
    (cnt == CW'(BLANK_CYCLES - 1));
  assign slot_end = (state == DRIVE) &&
    (cnt == CW'(PRESCALE - 1));
  assign frame_end = slot_end &&
    (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      state <= BLANK;
    end else begin
      state <= state_nx;
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      BLANK: if (blank_end) state_nx = DRIVE;
      DRIVE: if (slot_end)  state_nx = BLANK;
      default: state_nx = BLANK;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// Double-buffered 4-digit scanner with
// dead-time and leading-zero blanking.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  display_scanner_if.slave  bus
);

  state_t      state;
  logic [1:0]  idx;
  logic        frame_end;
  logic [19:0] shadow;
  logic [15:0] disp;
  logic [3:0]  dp_reg;
  logic        pending;
  logic [NUM_DIGITS-1:0] blank;
  logic        zero_run;
  logic        lit;

  scan_timer #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state),
    .idx       (idx),
    .frame_end (frame_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      disp    <= '0;
      dp_reg  <= '0;
      pending <= 1'b0;
    end else begin
      if (bus.load)
        shadow <= {bus.dp_mask, bus.data};
      if (frame_end) begin
        pending <= 1'b0;
        // a load on the boundary goes straight to the display
        if (bus.load)
          {dp_reg, disp} <= {bus.dp_mask, bus.data};
        else if (pending)
          {dp_reg, disp} <= shadow;
      end else if (bus.load) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run &&
        (disp[4*i +: 4] == 4'h0);
      blank[i] = bus.lzb && zero_run;
    end
  end

  assign lit = (state == DRIVE) && !blank[idx];

  assign bus.pending = pending;
  assign bus.nibble  = disp[{idx, 2'b00} +: 4];
  assign bus.an = lit ? ~(4'b0001 << idx)
                      : ANODE_OFF;
  assign bus.dp = lit ? ~dp_reg[idx] : 1'b1;

endmodule
